control_filtro_iir: RTL

CONTROL_FILTRO_IIR -- requirements
Module: control_filtro_iir

---
 rtl/control_filtro_iir.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/control_filtro_iir.sv
// Second-order IIR filter controller: one shared multiplier, 40-bit accumulator, coefficients from an external ROM.
// Optional 16-bit sample counter output enabled by FILTRO_CONTADOR_MUESTRAS_EN.
module control_filtro_iir #(
  parameter int unsigned cant_bits = 25
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inicio,
  input  logic                 limpiar,
  input  logic [cant_bits-1:0] x_in,
  input  logic [cant_bits-1:0] cte,
  output logic [3:0]           sel_cte,
  output logic [cant_bits-1:0] y_out,
  output logic                 listo,
  output logic                 ocupado
`ifdef FILTRO_CONTADOR_MUESTRAS_EN
  ,
  output logic [15:0]          cuenta_muestras
`endif
);

  localparam int unsigned ACC_W  = 40;
  localparam int unsigned FRAC   = 14;
  localparam int unsigned PROD_W = 2 * cant_bits;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (cant_bits - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(64'sd1 <<< (cant_bits - 1)));

  typedef enum logic [2:0] {
    REPOSO, MAC_B0, MAC_B1, MAC_B2, MAC_A1, MAC_A2, FIN
  } estado_t;

  estado_t                     r_estado, w_estado_sig;
  logic signed [cant_bits-1:0] r_x0, r_x1, r_x2, r_y1, r_y2;
  logic signed [ACC_W-1:0]     r_acc;
  logic [cant_bits-1:0]        r_y_out;
  logic                        r_listo, r_ocupado;
  logic [3:0]                  r_sel;
  logic [3:0]                  w_sel_sig;
  logic signed [cant_bits-1:0] w_oper;
  logic                        w_mac;
  logic signed [PROD_W-1:0]    w_prod;
  logic signed [ACC_W-1:0]     w_term;
  logic signed [cant_bits-1:0] w_sat;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_estado <= REPOSO;
    else       r_estado <= w_estado_sig;
  end

  // Next state, operand select for the current MAC step, ROM address for the next state
  always_comb begin
    w_estado_sig = r_estado;
    w_oper       = '0;
    w_mac        = 1'b0;
    w_sel_sig    = 4'b0000;
    case (r_estado)
      REPOSO: if (inicio) w_estado_sig = MAC_B0;
      MAC_B0: begin w_oper = r_x0; w_mac = 1'b1; w_estado_sig = MAC_B1; end
      MAC_B1: begin w_oper = r_x1; w_mac = 1'b1; w_estado_sig = MAC_B2; end
      MAC_B2: begin w_oper = r_x2; w_mac = 1'b1; w_estado_sig = MAC_A1; end
      MAC_A1: begin w_oper = r_y1; w_mac = 1'b1; w_estado_sig = MAC_A2; end
      MAC_A2: begin w_oper = r_y2; w_mac = 1'b1; w_estado_sig = FIN;    end
      FIN:    w_estado_sig = REPOSO;
      default: w_estado_sig = REPOSO;
    endcase
    if (limpiar) w_estado_sig = REPOSO;
    case (w_estado_sig)
      MAC_B0:  w_sel_sig = 4'b0101;
      MAC_B1:  w_sel_sig = 4'b0110;
      MAC_B2:  w_sel_sig = 4'b0111;
      MAC_A1:  w_sel_sig = 4'b0001;
      MAC_A2:  w_sel_sig = 4'b0010;
      default: w_sel_sig = 4'b0000;
    endcase
  end

  // Full-width product, floor-shifted back to 14 fractional bits
  assign w_prod = $signed(cte) * w_oper;
  assign w_term = ACC_W'(w_prod >>> FRAC);

  always_comb begin
    w_sat = cant_bits'(r_acc);
    if (r_acc > SAT_MAX)      w_sat = cant_bits'(SAT_MAX);
    else if (r_acc < SAT_MIN) w_sat = cant_bits'(SAT_MIN);
  end

  // Datapath: history, accumulator, registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x0 <= '0; r_x1 <= '0; r_x2 <= '0; r_y1 <= '0; r_y2 <= '0;
      r_acc     <= '0;
      r_y_out   <= '0;
      r_listo   <= 1'b0;
      r_ocupado <= 1'b0;
      r_sel     <= 4'b0000;
    end else begin
      r_listo   <= 1'b0;
      r_ocupado <= (w_estado_sig != REPOSO);
      r_sel     <= w_sel_sig;
      if (limpiar) begin
        r_x0 <= '0; r_x1 <= '0; r_x2 <= '0; r_y1 <= '0; r_y2 <= '0;
        r_acc <= '0;
      end else begin
        if (r_estado == REPOSO && inicio) begin
          r_x0  <= $signed(x_in);
          r_acc <= '0;
        end
        if (w_mac) r_acc <= r_acc + w_term;
        if (r_estado == FIN) begin
          r_y_out <= w_sat;
          r_listo <= 1'b1;
          r_x2    <= r_x1;
          r_x1    <= r_x0;
          r_y2    <= r_y1;
          r_y1    <= w_sat;
        end
      end
    end
  end

  assign sel_cte = r_sel;
  assign y_out   = r_y_out;
  assign listo   = r_listo;
  assign ocupado = r_ocupado;

`ifdef FILTRO_CONTADOR_MUESTRAS_EN
  logic [15:0] r_cuenta;

  // Counts delivered samples, wraps naturally at 16 bits
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              r_cuenta <= '0;
    else if (limpiar)                       r_cuenta <= '0;
    else if (r_estado == FIN)               r_cuenta <= r_cuenta + 16'd1;
  end

  assign cuenta_muestras = r_cuenta;
`endif

endmodule
